dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares one single-port dmem (8-bit word address, synchronous read) between two requesters:
//  port 0 = cardinal_processor, port 1 = NIC/DMA loader. Port 0 has priority; port 1 is
//  protected by a starvation counter. Sits between the requesters and dmem in each CMP node.
// PARAMETERS
//  ADDR_WIDTH  32  requester address width (big-endian bit order [0:N-1])
//  DATA_WIDTH  64  data word width
//  MEM_AW      8   dmem address width; memAddr = addr[ADDR_WIDTH-MEM_AW:ADDR_WIDTH-1]
//  MAX_WAIT    4   consecutive lost cycles after which port 1 is forced to win (1..15)
// PORTS
//  clk        in   1           clock, all state on rising edge
//  reset      in   1           asynchronous, active-high reset
//  req0/req1  in   1           access request, held until granted
//  wr0/wr1    in   1           1 = write, 0 = read
//  addr0/1    in   ADDR_WIDTH  access address
//  wdata0/1   in   DATA_WIDTH  write data
//  gnt0/gnt1  out  1           combinational; access issued to dmem this cycle
//  rvalid0/1  out  1           registered; read data valid (one cycle after read grant)
//  rdata      out  DATA_WIDTH  = memDataOut, qualify with rvalidN
//  memEn, memWrEn  out  1      dmem enable / write enable
//  memAddr    out  MEM_AW      dmem word address
//  memDataIn  out  DATA_WIDTH  dmem write data
//  memDataOut in   DATA_WIDTH  dmem read data (valid cycle after memEn&!memWrEn)
// BEHAVIOUR
//  - Reset: gnt*, rvalid*, memEn, memWrEn = 0; memAddr, memDataIn = 0; wait_cnt = 0; owner = NONE.
//  - Winner each cycle: force1 = (wait_cnt == MAX_WAIT) & req1. If force1 -> port1;
//    else if req0 -> port0; else if req1 -> port1; else none. Exactly one gnt max, never gnt w/o req.
//  - memEn = gnt0|gnt1; memWrEn/memAddr/memDataIn muxed from winner; all 0 when idle.
//  - wait_cnt: +1 when req1 & !gnt1 (saturates at MAX_WAIT); cleared when gnt1 or !req1.
//  - Read-return FSM owner {NONE,P0,P1}: next = P0 on read gnt0, P1 on read gnt1, else NONE.
//    rvalidN = (owner==PN). Writes produce no rvalid. Back-to-back reads pipeline, 1/cycle.
//  - Simultaneous req0 & req1 with wait_cnt<MAX_WAIT: port0 wins, port1 waits (counter +1).
//  - Latency: grant 0 cycles after req if winning; read data 1 cycle after grant.
//  - Reset mid-read: pending rvalid dropped, owner=NONE; requesters must reissue.
//  - Requester losing must hold req/wr/addr/wdata stable (bench checks; arbiter does not latch).
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs stat_gnt0, stat_gnt1, stat_conflict (32 bit each),
//   counting grants per port and cycles with req0&req1; wrap at 2^32; cleared by reset.
//  Undefined: those ports and counters do not exist; arbitration identical.
// STRUCTURE
//  Shared package/include (dmem_arb_defs): owner encoding localparams OWN_NONE=2'b00,
//  OWN_P0=2'b01, OWN_P1=2'b10; MEM_AW default. One natural sub-module:
//  dmem_arb_starve_cnt (wait_cnt saturating counter + force1 output). Rest flat.
// TESTING
//  1 req0 read addr 0x0000_0010 alone -> gnt0 same cycle, memAddr=0x10, rvalid0 next cycle
//    with rdata = dmem[0x10]; rvalid1 stays 0.
//  2 req0 and req1 both held every cycle, MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on 5th,
//    then wait_cnt=0 and pattern repeats (4:1 ratio).
//  3 req1 write 0xDEAD_BEEF_0000_0001 to 0x20 while req0 idle -> gnt1, memWrEn=1,
//    no rvalid; later port0 read of 0x20 returns that value.
//  4 alternating reads: cycle n port0 @0x01, n+1 port1 @0x02 -> rvalid0 at n+1, rvalid1 at n+2,
//    each with correct word, never both high.
//  5 assert reset in cycle between read grant and rvalid -> rvalid stays 0, all outputs 0
//    immediately (async), normal arbitration resumes after release.
//  6 STATS_EN build, 10 cycles of req0&req1 -> stat_conflict=10, stat_gnt0+stat_gnt1=10.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the dmem port arbiter: read-return owner encoding and dmem address width default.
package dmem_port_arbiter_pkg;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_P0   = 2'b01;
    localparam logic [1:0] OWN_P1   = 2'b10;

    localparam int MEM_AW_DEFAULT = 8;

    typedef enum logic [1:0] {
        OWNER_NONE = OWN_NONE,
        OWNER_P0   = OWN_P0,
        OWNER_P1   = OWN_P1
    } owner_t;
endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester and dmem bus of the dmem port arbiter. master = requesters plus dmem, slave = arbiter.
// Handshake: reqN is held with wrN/addrN/wdataN stable until gntN is seen high in the same cycle;
// gntN means the access went to dmem this cycle; a read returns on rdata one cycle later, flagged by rvalidN.
interface dmem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_AW     = dmem_port_arbiter_pkg::MEM_AW_DEFAULT
);
    logic                  req0, req1;
    logic                  wr0, wr1;
    logic [0:ADDR_WIDTH-1] addr0, addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0, gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  memEn, memWrEn;
    logic [MEM_AW-1:0]     memAddr;
    logic [DATA_WIDTH-1:0] memDataIn;
    logic [DATA_WIDTH-1:0] memDataOut;

    modport master (
        output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, memDataOut,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, memEn, memWrEn, memAddr, memDataIn
    );

    modport slave (
        input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, memDataOut,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, memEn, memWrEn, memAddr, memDataIn
    );
endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive cycles port 1 requested and lost; force1 hands port 1 the next win once MAX_WAIT is reached.
module dmem_arb_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req1,
    input  logic       gnt1,
    output logic       force1,
    output logic [3:0] wait_cnt
);
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= 4'd0;
        end else if (gnt1 || !req1) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign force1 = (wait_cnt == WAIT_LIMIT) && req1;
endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read dmem; port 0 has priority, port 1 is starvation-protected.
// Define DMEM_ARB_STATS_EN to add grant/conflict statistics counters.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_AW     = MEM_AW_DEFAULT,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_port_arbiter_if.slave bus,
    output owner_t            owner
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_conflict
`endif
);
    logic                  force1;
    logic [3:0]            wait_cnt;
    logic                  gnt0_c, gnt1_c;
    logic                  wr_sel;
    logic [MEM_AW-1:0]     addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;
    logic                  rvalid0_q, rvalid1_q;

    dmem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk      (clk),
        .reset    (reset),
        .req1     (bus.req1),
        .gnt1     (gnt1_c),
        .force1   (force1),
        .wait_cnt (wait_cnt)
    );

    // Grants are gated by reset so every output drops the instant reset is asserted.
    always_comb begin
        gnt0_c    = 1'b0;
        gnt1_c    = 1'b0;
        wr_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        if (!reset) begin
            if (force1)        gnt1_c = 1'b1;
            else if (bus.req0) gnt0_c = 1'b1;
            else if (bus.req1) gnt1_c = 1'b1;
        end
        if (gnt0_c) begin
            wr_sel    = bus.wr0;
            addr_sel  = bus.addr0[ADDR_WIDTH-MEM_AW:ADDR_WIDTH-1];
            wdata_sel = bus.wdata0;
        end else if (gnt1_c) begin
            wr_sel    = bus.wr1;
            addr_sel  = bus.addr1[ADDR_WIDTH-MEM_AW:ADDR_WIDTH-1];
            wdata_sel = bus.wdata1;
        end
    end

    assign bus.gnt0      = gnt0_c;
    assign bus.gnt1      = gnt1_c;
    assign bus.memEn     = gnt0_c | gnt1_c;
    assign bus.memWrEn   = wr_sel;
    assign bus.memAddr   = addr_sel;
    assign bus.memDataIn = wdata_sel;
    assign bus.rdata     = bus.memDataOut;
    assign bus.rvalid0   = rvalid0_q;
    assign bus.rvalid1   = rvalid1_q;

    // Read-return owner: remembers which port's read is coming back from dmem next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWNER_NONE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt0_c && !bus.wr0;
            rvalid1_q <= gnt1_c && !bus.wr1;
            if (gnt0_c && !bus.wr0)      owner <= OWNER_P0;
            else if (gnt1_c && !bus.wr1) owner <= OWNER_P1;
            else                         owner <= OWNER_NONE;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_gnt0     <= 32'd0;
            stat_gnt1     <= 32'd0;
            stat_conflict <= 32'd0;
        end else begin
            if (gnt0_c)               stat_gnt0     <= stat_gnt0 + 32'd1;
            if (gnt1_c)               stat_gnt1     <= stat_gnt1 + 32'd1;
            if (bus.req0 && bus.req1) stat_conflict <= stat_conflict + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter with a transaction-level reference model and a dmem model.
// Build with DMEM_ARB_STATS_EN defined to also check the statistics counters.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        we;
        logic [7:0]  ma;
        logic [63:0] wd;
        logic        v0;
        logic        v1;
        logic [63:0] rd;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset = 1'b1;
    logic   mem_init = 1'b1;
    logic   mon_en = 1'b0;
    owner_t owner;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

    dmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_AW(8)) bus ();

    dmem_port_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_AW(8), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .owner (owner)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- dmem model ----------------
    logic [63:0] dmem [256];
    logic [31:0] mem_seed;

    function automatic logic [63:0] init_word(input int i, input logic [31:0] seed);
        return {seed ^ (32'(i) * 32'h9E37_79B9), 32'(i) * 32'h0100_0193};
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) dmem[i] <= init_word(i, mem_seed);
        end else if (bus.memEn) begin
            if (bus.memWrEn) dmem[bus.memAddr] <= bus.memDataIn;
            else             bus.memDataOut <= dmem[bus.memAddr];
        end
    end

    // ---------------- scoreboard state ----------------
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   mon_gnt1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [256];
    logic        p0_pend = 1'b0, p1_pend = 1'b0;
    logic        p0_wr, p1_wr;
    logic [31:0] p0_addr, p1_addr;
    logic [63:0] p0_wdata, p1_wdata;
    int          losses = 0;
    int          prev_port = -1;
    logic [63:0] prev_rd = '0;
    int          m_g0 = 0, m_g1 = 0, m_conf = 0;

    function automatic logic [31:0] rand_addr();
        logic [31:0] hi;
        logic [7:0]  lo;
        hi = $urandom;
        case ($urandom_range(4))
            0:       lo = 8'h01;
            1:       lo = 8'h02;
            2:       lo = 8'h10;
            3:       lo = 8'h20;
            default: lo = 8'($urandom);
        endcase
        return {hi[31:8], lo};
    endfunction

    // One cycle of the arbitration rules applied to the pending requests.
    task automatic model_step();
        exp_t e;
        int   win;
        e = '0;
        e.v0 = (prev_port == 0);
        e.v1 = (prev_port == 1);
        e.rd = (prev_port >= 0) ? prev_rd : 64'd0;
        if (p1_pend && losses >= MAX_WAIT) win = 1;
        else if (p0_pend)                  win = 0;
        else if (p1_pend)                  win = 1;
        else                               win = -1;
        if (p0_pend && p1_pend) m_conf++;
        if (p1_pend && win != 1) losses = (losses < MAX_WAIT) ? losses + 1 : MAX_WAIT;
        else                     losses = 0;
        prev_port = -1;
        if (win == 0) begin
            e.g0 = 1'b1; e.we = p0_wr; e.ma = p0_addr[7:0]; e.wd = p0_wdata;
            if (p0_wr) ref_mem[p0_addr[7:0]] = p0_wdata;
            else begin prev_port = 0; prev_rd = ref_mem[p0_addr[7:0]]; end
            p0_pend = 1'b0;
            m_g0++;
        end else if (win == 1) begin
            e.g1 = 1'b1; e.we = p1_wr; e.ma = p1_addr[7:0]; e.wd = p1_wdata;
            if (p1_wr) ref_mem[p1_addr[7:0]] = p1_wdata;
            else begin prev_port = 1; prev_rd = ref_mem[p1_addr[7:0]]; end
            p1_pend = 1'b0;
            m_g1++;
        end
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic run_cycles(input int n, input int p0_pct, input int p1_pct);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (!p0_pend && $urandom_range(99) < p0_pct) begin
                p0_pend = 1'b1; p0_wr = 1'($urandom_range(1));
                p0_addr = rand_addr(); p0_wdata = {$urandom, $urandom};
            end
            if (!p1_pend && $urandom_range(99) < p1_pct) begin
                p1_pend = 1'b1; p1_wr = 1'($urandom_range(1));
                p1_addr = rand_addr(); p1_wdata = {$urandom, $urandom};
            end
            bus.req0 = p0_pend; bus.wr0 = p0_wr; bus.addr0 = p0_addr; bus.wdata0 = p0_wdata;
            bus.req1 = p1_pend; bus.wr1 = p1_wr; bus.addr1 = p1_addr; bus.wdata1 = p1_wdata;
            model_step();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && (p0_pend || p1_pend); k++) run_cycles(1, 0, 0);
        check("drain_pending", 64'(p0_pend | p1_pend), 64'd0);
        run_cycles(2, 0, 0);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        check("drain_queue", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            mon_gnt1 += int'(bus.gnt1);
            check("grant", 64'({bus.gnt0, bus.gnt1}), 64'({e.g0, e.g1}));
            check("mem_ctrl", 64'({bus.memEn, bus.memWrEn, bus.memAddr}),
                  64'({e.g0 | e.g1, e.we, e.ma}));
            check("mem_wdata", bus.memDataIn, e.wd);
            check("rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'({e.v0, e.v1}));
            if (e.v0 || e.v1) check("rdata", bus.rdata, e.rd);
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int g1_start;
        mem_seed = $urandom;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i, mem_seed);
        bus.req0 = 1'b1; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
        bus.addr0 = 32'h0000_0010; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        p0_wr = 1'b0; p1_wr = 1'b0; p0_addr = '0; p1_addr = '0; p0_wdata = '0; p1_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        // Reset state, with a request held so grant gating is exercised.
        check("rst_gnt", 64'({bus.gnt0, bus.gnt1}), 64'd0);
        check("rst_mem", 64'({bus.memEn, bus.memWrEn, bus.memAddr}), 64'd0);
        check("rst_wdata", bus.memDataIn, 64'd0);
        check("rst_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
        check("rst_owner", 64'(owner), 64'(OWNER_NONE));
        bus.req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_init = 1'b0;
        mon_en = 1'b1;

        // Both ports requesting every cycle: port 1 wins once per MAX_WAIT+1 cycles.
        g1_start = mon_gnt1;
        run_cycles(20, 100, 100);
        drain();
        check("starve_ratio", 64'(mon_gnt1 - g1_start), 64'd4);

        run_cycles(400, 60, 45);
        drain();

        // Reset landing between a read grant and its return.
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        bus.req0 = 1'b1; bus.wr0 = 1'b0; bus.addr0 = 32'h0000_0010; bus.req1 = 1'b0;
        #1;
        check("pre_rst_gnt0", 64'({bus.gnt0, bus.memEn, bus.memAddr}), 64'({2'b11, 8'h10}));
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_gnt", 64'({bus.gnt0, bus.gnt1, bus.memEn, bus.memWrEn}), 64'd0);
        check("async_rst_addr", 64'(bus.memAddr), 64'd0);
        @(posedge clk);
        #1;
        check("rst_drop_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'd0);
        check("rst_drop_owner", 64'(owner), 64'(OWNER_NONE));
        bus.req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        losses = 0; prev_port = -1; m_g0 = 0; m_g1 = 0; m_conf = 0;
        p0_pend = 1'b0; p1_pend = 1'b0;
        mon_en = 1'b1;

        run_cycles(200, 50, 50);
        drain();

`ifdef DMEM_ARB_STATS_EN
        check("stat_gnt0", 64'(stat_gnt0), 64'(m_g0));
        check("stat_gnt1", 64'(stat_gnt1), 64'(m_g1));
        check("stat_conflict", 64'(stat_conflict), 64'(m_conf));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so a stalled run still reports.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
